// File: rtl/kiana_sched_pkg.sv
// Shared types and constants for the warp scheduler: instruction-buffer entry
// layout, feature-flag bit positions and the scheduler FSM encoding.
package kiana_sched_pkg;

    localparam int NUM_WARPS = 32;
    localparam int WID_W     = $clog2(NUM_WARPS);

    localparam int FF_WR_GPR  = 0;
    localparam int FF_WR_UNIR = 1;
    localparam int FF_WR_PC   = 2;
    localparam int FF_WR_PRED = 3;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [7:0]  feature_flags;
    } ib_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest set bit of mask strictly above ptr,
// wrapping back through 0; ptr itself is considered last.
module rr_arbiter #(
    parameter int NUM_WARPS = kiana_sched_pkg::NUM_WARPS,
    parameter int WID_W     = kiana_sched_pkg::WID_W
) (
    input  logic [NUM_WARPS-1:0] mask,
    input  logic [WID_W-1:0]     ptr,
    output logic                 grant_valid,
    output logic [WID_W-1:0]     grant_idx
);

    logic [WID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_WARPS; i >= 1; i--) begin
            cand = ptr + WID_W'(i);
            if (mask[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: picks a ready warp, reads its head entry, strobes
// the scoreboard reservation and holds the issued instruction on a valid/ready output.
module warp_scheduler #(
    parameter int NUM_WARPS = kiana_sched_pkg::NUM_WARPS,
    parameter int WID_W     = kiana_sched_pkg::WID_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WARPS-1:0] warp_ready_mask,
    input  logic [62:0]          instruction_buffer,
    output logic [WID_W-1:0]     target_warp,
    output logic [4:0]           target_gpr_in,
    output logic [4:0]           target_unir_in,
    output logic                 target_is_pc,
    output logic                 target_is_pred,
    output logic                 s_tvalid_schedular,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [WID_W-1:0]     m_warp_id,
    output logic [7:0]           m_opcode,
    output logic [4:0]           m_rd,
    output logic [4:0]           m_rs1,
    output logic [4:0]           m_rs2,
    output logic [31:0]          m_imm,
    output logic [7:0]           m_feature_flags,
    output logic                 err
);

    import kiana_sched_pkg::*;

    sched_state_t         state_q, state_d;
    logic [WID_W-1:0]     rr_ptr;
    logic [NUM_WARPS-1:0] block;
    logic [NUM_WARPS-1:0] eligible;
    logic                 pick_valid;
    logic [WID_W-1:0]     pick_idx;
    logic                 slot_free;
    logic                 head_ready;
    logic                 issue;
    ib_entry_t            entry;

    assign entry      = ib_entry_t'(instruction_buffer);
    // The scoreboard clears the just-issued warp's ready bit one cycle late.
    assign eligible   = warp_ready_mask & ~block;
    assign slot_free  = !m_tvalid || m_tready;
    assign head_ready = warp_ready_mask[target_warp];
    assign issue      = (state_q == READ) && head_ready;

    rr_arbiter #(
        .NUM_WARPS (NUM_WARPS),
        .WID_W     (WID_W)
    ) u_rr_arbiter (
        .mask        (eligible),
        .ptr         (rr_ptr),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid && slot_free) state_d = READ;
            READ:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_tvalid_schedular = 1'b0;
        err                = 1'b0;
        target_gpr_in      = '0;
        target_unir_in     = '0;
        target_is_pc       = 1'b0;
        target_is_pred     = 1'b0;
        if (state_q == READ) begin
            if (head_ready) begin
                s_tvalid_schedular = 1'b1;
                target_gpr_in      = entry.feature_flags[FF_WR_GPR]  ? entry.rd : 5'd0;
                target_unir_in     = entry.feature_flags[FF_WR_UNIR] ? entry.rd : 5'd0;
                target_is_pc       = entry.feature_flags[FF_WR_PC];
                target_is_pred     = entry.feature_flags[FF_WR_PRED];
            end else begin
                err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_warp <= '0;
            rr_ptr      <= WID_W'(NUM_WARPS - 1);
            block       <= '0;
        end else begin
            block <= issue ? ({{(NUM_WARPS-1){1'b0}}, 1'b1} << target_warp) : '0;
            if (issue) rr_ptr <= target_warp;
            if ((state_q == IDLE) && (state_d == READ)) target_warp <= pick_idx;
        end
    end

    // A load in the same cycle as an accept wins, keeping m_tvalid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid        <= 1'b0;
            m_warp_id       <= '0;
            m_opcode        <= '0;
            m_rd            <= '0;
            m_rs1           <= '0;
            m_rs2           <= '0;
            m_imm           <= '0;
            m_feature_flags <= '0;
        end else if (issue) begin
            m_tvalid        <= 1'b1;
            m_warp_id       <= target_warp;
            m_opcode        <= entry.opcode;
            m_rd            <= entry.rd;
            m_rs1           <= entry.rs1;
            m_rs2           <= entry.rs2;
            m_imm           <= entry.imm;
            m_feature_flags <= entry.feature_flags;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule
